pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline-stage register with per-source arbitration and a two-entry skid buffer. Each cycle it selects one of K candidate inputs by fixed priority, captures it under a valid/ready handshake, and presents it downstream. When the consumer stalls, it absorbs one extra word without losing data. It replaces hold/load-select latches between pipeline stages that need stall, flush and back-pressure.

## Interface
- N, default 32: data width in bits.
- K, default 3: number of candidate sources, with K ≥ 1.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_vld  in  K  per-source request; bit i means src_data slice i is offered.
- src_data  in  N*K  packed source data; source i occupies bits [N*i+N-1 : N*i].
- src_gnt  out  K  one-hot, combinational; the source accepted this cycle, all-zero if none.
- in_rdy  out  1  registered; the stage can accept a word this cycle.
- flush  in  1  synchronous discard of all held words.
- out_vld  out  1  registered; out_data is valid.
- out_data  out  N  registered head word.
- out_src  out  K  registered one-hot identity of the source that produced out_data.
- out_rdy  in  1  the consumer takes the head word this cycle.
- occ  out  2  registered occupancy, 0..2.

## Operation
- **State:** head entry (data, src, valid hv) and skid entry (data, src, valid sv). The invariant sv=1 implies hv=1.
- **Arbitration:** the lowest-index asserted src_vld wins.
  - acc = in_rdy & |src_vld & ~flush.
  - src_gnt = one-hot winner when acc, otherwise 0.
- **Handshake:** deq = hv & out_rdy. The term in_rdy = ~sv. out_vld = hv. occ = hv + sv.
- **Next-state rules, first match wins:**
  1. flush: hv←0, sv←0. Any input is ignored (src_gnt=0) and any dequeue is void.
  2. hv=0: if acc, head←winner and hv←1.
  3. hv=1, deq, sv=1: head←skid and sv←0. acc is impossible because in_rdy=0.
  4. hv=1, deq, sv=0: if acc, head←winner (hv stays 1); otherwise hv←0.
  5. hv=1, ~deq: if acc, skid←winner and sv←1.
- **Data retention:** data and src registers load only as listed above and otherwise hold. They are not cleared by flush. out_data and out_src are meaningful only while out_vld=1.
- **Reset (async, while rst_n=0):**
  - hv=sv=0, so out_vld=0, occ=0, in_rdy=1.
  - out_data=0 and out_src=0.
  - Reset asserted mid-transfer drops both entries immediately. The first accept after release is allowed on the first edge with rst_n=1.
- **Ordering:** words leave in acceptance order. A word is never duplicated or dropped except by flush or reset.

## Timing
- Latency: 1 cycle from accept edge to out_vld=1 when hv=0 or when deq happens in the same cycle.
- Throughput: 1 word/cycle sustained while out_rdy=1, with no bubbles.
- Stall absorption: on the first stall cycle with acc, the word goes to skid. in_rdy falls the following cycle, so producers see at most one extra accept after out_rdy drops.
- Recovery: in the cycle out_rdy returns with sv=1, the skid word moves to head. in_rdy=1 from the next cycle.
- Flush: flush=1 at edge T gives out_vld=0, occ=0, in_rdy=1 after T. An accept is possible on edge T+1.
- src_gnt is the only combinational output. Its path is src_vld/flush → src_gnt, with no path from out_rdy.

## Test plan
- **Reset:** assert rst_n=0 asynchronously mid-cycle with occ=2 → out_vld=0, occ=0, in_rdy=1, out_data=0 without waiting for a clock edge.
- **Priority:** src_vld=3'b110 with data {C,B,A}=0x33,0x22,0x11, out_rdy=1.
  - src_gnt=3'b010.
  - Next cycle: out_data=0x22, out_src=3'b010.
  - With src_vld=3'b111, the grant goes to source 0 (0x11).
- **Streaming:** source 0 offers 0x1..0x8 on consecutive cycles with out_rdy=1 → eight consecutive out_vld cycles carrying 0x1..0x8 in order, occ never above 1.
- **Stall/skid:** stream 0xA0,0xA1,0xA2 and drop out_rdy on the cycle 0xA0 is at head.
  - 0xA1 is accepted into skid, occ=2, in_rdy=0, and 0xA2 is not granted.
  - When out_rdy rises: outputs 0xA0, 0xA1, 0xA2 with no loss.
- **Flush:** flush at occ=2 with src_vld=1 on the same cycle.
  - src_gnt=0, then occ=0, out_vld=0.
  - The next offered 0x55 appears at head after 1 cycle.
- **Simultaneous dequeue and accept:** at occ=1, out_rdy=1 and src_vld=1 → occ stays 1, head is replaced by the new word, continuously for 16 cycles with random data and scoreboard match.

Source files
------------

// File: rtl/pipe_skid_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg_if
//
// Bundle of the handshake and data signals around one pipe_skid_reg stage.
//
// Parameters:
//   N : data width in bits
//   K : number of candidate sources (K >= 1)
//
// Signals:
//   src_vld  [K-1:0]   per-source request, bit i offers slice i of src_data
//   src_data [N*K-1:0] packed source words, source i at [N*i +: N]
//   src_gnt  [K-1:0]   one-hot source accepted this cycle (combinational)
//   in_rdy             stage can accept a word this cycle (registered)
//   flush              synchronous discard of all held words
//   out_vld            out_data / out_src are valid (registered)
//   out_data [N-1:0]   head word (registered)
//   out_src  [K-1:0]   one-hot source that produced out_data (registered)
//   out_rdy            consumer takes the head word this cycle
//   occ      [1:0]     number of held words, 0..2 (registered)
//
// Modports:
//   slave  : the pipeline stage itself
//   master : whatever surrounds the stage (producers, consumer, control)
// ---------------------------------------------------------------------------
interface pipe_skid_reg_if #(
  parameter int N = 32,
  parameter int K = 3
);

  logic [K-1:0]   src_vld;
  logic [N*K-1:0] src_data;
  logic [K-1:0]   src_gnt;
  logic           in_rdy;
  logic           flush;
  logic           out_vld;
  logic [N-1:0]   out_data;
  logic [K-1:0]   out_src;
  logic           out_rdy;
  logic [1:0]     occ;

  modport slave (
    input  src_vld,
    input  src_data,
    input  flush,
    input  out_rdy,
    output src_gnt,
    output in_rdy,
    output out_vld,
    output out_data,
    output out_src,
    output occ
  );

  modport master (
    output src_vld,
    output src_data,
    output flush,
    output out_rdy,
    input  src_gnt,
    input  in_rdy,
    input  out_vld,
    input  out_data,
    input  out_src,
    input  occ
  );

endinterface

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// Pipeline-stage register with fixed-priority selection among K sources and a
// two-entry (head + skid) buffer, so a stalled consumer never loses the one
// word that was accepted in the same cycle the stall appeared.
//
// Parameters:
//   N : data width in bits (default 32)
//   K : number of candidate sources (default 3, K >= 1)
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pipe_skid_reg_if.slave, see the interface file for the signals
//
// Handshake semantics:
//   A word moves from source i into the stage on a rising edge where
//   src_gnt[i]=1; src_gnt is only raised when in_rdy=1, src_vld[i]=1, no
//   lower-index source is requesting and flush=0. A word leaves the stage on
//   a rising edge where out_vld=1 and out_rdy=1. in_rdy depends only on the
//   stage's own state, never on out_rdy, so there is no combinational path
//   from the consumer back to the producers. flush discards everything held
//   and blocks both directions for that cycle.
//
// State:
//   The buffer is a three-state machine (EMPTY, HEAD, FULL). Its encoding is
//   the occupancy, and occ is a registered copy of it, so the state is always
//   observable at the port.
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int N = 32,
  parameter int K = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_skid_reg_if.slave bus
);

  // Encoding equals occupancy: EMPTY=0, HEAD=1 (hv only), FULL=2 (hv and sv).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HEAD  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;

  // Registered outputs, all decoded from the next state at the clock edge.
  logic         out_vld_q;
  logic         in_rdy_q;
  logic [1:0]   occ_q;

  // Head and skid storage. These hold their value unless explicitly loaded;
  // flush only clears the valid bits (via the state), not the words.
  logic [N-1:0] head_data_q;
  logic [K-1:0] head_src_q;
  logic [N-1:0] skid_data_q;
  logic [K-1:0] skid_src_q;

  // Arbitration results.
  logic [K-1:0] win_oh;
  logic [N-1:0] win_data;
  logic         any_vld;
  logic         acc;
  logic         deq;

  // Load strobes for the storage registers.
  logic         load_head_win;
  logic         load_head_skid;
  logic         load_skid;

  // -------------------------------------------------------------------------
  // Fixed-priority selection: the lowest-index requesting source wins.
  // -------------------------------------------------------------------------
  always_comb begin
    logic found;
    found    = 1'b0;
    win_oh   = '0;
    win_data = '0;
    for (int i = 0; i < K; i++) begin
      if (bus.src_vld[i] && !found) begin
        found     = 1'b1;
        win_oh[i] = 1'b1;
        win_data  = bus.src_data[i*N +: N];
      end
    end
  end

  assign any_vld = |bus.src_vld;

  // in_rdy_q is low only in FULL, so a grant can never coincide with the
  // skid-to-head move; flush suppresses the grant outright.
  assign acc = in_rdy_q & any_vld & ~bus.flush;

  // Only combinational output: a function of src_vld, flush and state only.
  assign bus.src_gnt = acc ? win_oh : '0;

  assign deq = out_vld_q & bus.out_rdy;

  // -------------------------------------------------------------------------
  // Next-state and load decisions. flush overrides everything, including a
  // dequeue in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    load_head_win  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;

    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            load_head_win = 1'b1;
            state_d       = ST_HEAD;
          end
        end

        ST_HEAD: begin
          if (deq) begin
            // Head leaves; a same-cycle arrival replaces it directly so a
            // steady stream runs at one word per cycle without bubbles.
            if (acc) begin
              load_head_win = 1'b1;
            end else begin
              state_d = ST_EMPTY;
            end
          end else if (acc) begin
            // Consumer stalled while a word was accepted: park it in skid.
            load_skid = 1'b1;
            state_d   = ST_FULL;
          end
        end

        ST_FULL: begin
          if (deq) begin
            load_head_skid = 1'b1;
            state_d        = ST_HEAD;
          end
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State and registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b1;
      occ_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      out_vld_q <= (state_d != ST_EMPTY);
      in_rdy_q  <= (state_d != ST_FULL);
      occ_q     <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage registers. Cleared by reset so out_data/out_src read zero then.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_q <= '0;
      head_src_q  <= '0;
      skid_data_q <= '0;
      skid_src_q  <= '0;
    end else begin
      if (load_head_win) begin
        head_data_q <= win_data;
        head_src_q  <= win_oh;
      end else if (load_head_skid) begin
        head_data_q <= skid_data_q;
        head_src_q  <= skid_src_q;
      end
      if (load_skid) begin
        skid_data_q <= win_data;
        skid_src_q  <= win_oh;
      end
    end
  end

  assign bus.out_vld  = out_vld_q;
  assign bus.in_rdy   = in_rdy_q;
  assign bus.occ      = occ_q;
  assign bus.out_data = head_data_q;
  assign bus.out_src  = head_src_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Bench for pipe_skid_reg. Inputs change 1 time unit after each rising edge;
// a negedge monitor compares every output against a queue of expected words
// and updates the queue according to the handshake that the next rising edge
// will perform. Directed checks cover reset, priority, stall/skid, flush and
// simultaneous dequeue/accept; a random section mixes everything.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int N = 32;
  localparam int K = 3;
  localparam int W = N + K;

  // -------------------------------------------------------------------------
  // Clock and reset
  // -------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.N(N), .K(K)) bus ();

  pipe_skid_reg #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state and checker
  // -------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [K-1:0] lowest_bit(input logic [K-1:0] v);
    logic [K-1:0] r;
    r = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] slice_of(input logic [K-1:0] oh, input logic [N*K-1:0] d);
    for (int i = 0; i < K; i++) begin
      if (oh[i]) return d[i*N +: N];
    end
    return '0;
  endfunction

  // -------------------------------------------------------------------------
  // Monitor: queue size is the expected occupancy, queue head the expected
  // output word {src, data}.
  // -------------------------------------------------------------------------
  logic [K-1:0] m_gnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      m_gnt = (!bus.flush && exp_q.size() < 2) ? lowest_bit(bus.src_vld) : '0;
      check("src_gnt", 64'(bus.src_gnt), 64'(m_gnt));
      check("out_vld", 64'(bus.out_vld), 64'(exp_q.size() > 0));
      check("occ",     64'(bus.occ),     64'(exp_q.size()));
      check("in_rdy",  64'(bus.in_rdy),  64'(exp_q.size() < 2));
      if (exp_q.size() > 0)
        check("out_word", 64'({bus.out_src, bus.out_data}), 64'(exp_q[0]));
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (bus.out_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_gnt != '0) exp_q.push_back({m_gnt, slice_of(m_gnt, bus.src_data)});
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic set_in(input logic [K-1:0] vld, input logic [N*K-1:0] data,
                        input logic ordy, input logic fl);
    bus.src_vld  = vld;
    bus.src_data = data;
    bus.out_rdy  = ordy;
    bus.flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
      set_in('0, '0, 1'b1, 1'b0);
      tick();
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [N*K-1:0] src0(input logic [N-1:0] d);
    return {{(N*(K-1)){1'b0}}, d};
  endfunction

  function automatic logic [N*K-1:0] rand_data();
    logic [N*K-1:0] d;
    for (int i = 0; i < K; i++) d[i*N +: N] = $urandom();
    return d;
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    bus.src_vld  = '0;
    bus.src_data = '0;
    bus.out_rdy  = 1'b0;
    bus.flush    = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vld",  64'(bus.out_vld),  64'd0);
    check("rst_occ",      64'(bus.occ),      64'd0);
    check("rst_in_rdy",   64'(bus.in_rdy),   64'd1);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_src",  64'(bus.out_src),  64'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // Priority.
    set_in(3'b110, {32'h33, 32'h22, 32'h11}, 1'b1, 1'b0);
    check("prio_gnt", 64'(bus.src_gnt), 64'(3'b010));
    tick();
    set_in(3'b111, {32'h33, 32'h22, 32'h11}, 1'b1, 1'b0);
    check("prio_data",    64'(bus.out_data), 64'h22);
    check("prio_src",     64'(bus.out_src),  64'(3'b010));
    check("prio_gnt_all", 64'(bus.src_gnt),  64'(3'b001));
    tick();
    drain();

    // Streaming 0x1..0x8 from source 0.
    for (int i = 1; i <= 8; i++) begin
      set_in(3'b001, src0(N'(i)), 1'b1, 1'b0);
      tick();
      check("stream_occ_le1", 64'(bus.occ <= 2'd1), 64'd1);
    end
    drain();

    // Stall / skid.
    set_in(3'b001, src0(32'hA0), 1'b1, 1'b0);
    tick();
    set_in(3'b001, src0(32'hA1), 1'b0, 1'b0);
    check("stall_head", 64'(bus.out_data), 64'hA0);
    tick();
    set_in(3'b001, src0(32'hA2), 1'b0, 1'b0);
    check("stall_occ",    64'(bus.occ),     64'd2);
    check("stall_in_rdy", 64'(bus.in_rdy),  64'd0);
    check("stall_no_gnt", 64'(bus.src_gnt), 64'd0);
    tick();
    set_in(3'b001, src0(32'hA2), 1'b1, 1'b0);
    tick();
    set_in(3'b001, src0(32'hA2), 1'b1, 1'b0);
    check("recover_head", 64'(bus.out_data), 64'hA1);
    check("recover_gnt",  64'(bus.src_gnt),  64'(3'b001));
    tick();
    drain();

    // Flush at occ=2 with a request in the same cycle.
    set_in(3'b001, src0(32'h11), 1'b0, 1'b0);
    tick();
    set_in(3'b001, src0(32'h12), 1'b0, 1'b0);
    tick();
    set_in(3'b001, src0(32'h13), 1'b1, 1'b1);
    check("flush_occ_before", 64'(bus.occ),     64'd2);
    check("flush_no_gnt",     64'(bus.src_gnt), 64'd0);
    tick();
    check("flush_occ",     64'(bus.occ),     64'd0);
    check("flush_out_vld", 64'(bus.out_vld), 64'd0);
    check("flush_in_rdy",  64'(bus.in_rdy),  64'd1);
    set_in(3'b001, src0(32'h55), 1'b0, 1'b0);
    tick();
    check("flush_next_vld",  64'(bus.out_vld),  64'd1);
    check("flush_next_data", 64'(bus.out_data), 64'h55);
    drain();

    // Simultaneous dequeue and accept at occ=1.
    set_in(3'b001, src0($urandom()), 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      set_in(3'b001, src0($urandom()), 1'b1, 1'b0);
      check("simul_occ", 64'(bus.occ), 64'd1);
      tick();
    end
    drain();

    // Random mix of requests, stalls and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      set_in(K'($urandom_range(0, 7)), rand_data(),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      tick();
    end
    drain();

    // Asynchronous reset mid-cycle with occ=2.
    set_in(3'b001, src0(32'h66), 1'b0, 1'b0);
    tick();
    set_in(3'b001, src0(32'h67), 1'b0, 1'b0);
    tick();
    set_in('0, '0, 1'b0, 1'b0);
    check("arst_occ_before", 64'(bus.occ), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_vld",  64'(bus.out_vld),  64'd0);
    check("arst_occ",      64'(bus.occ),      64'd0);
    check("arst_in_rdy",   64'(bus.in_rdy),   64'd1);
    check("arst_out_data", 64'(bus.out_data), 64'd0);
    check("arst_out_src",  64'(bus.out_src),  64'd0);
    #3;
    rst_n = 1'b1;
    set_in(3'b001, src0(32'h77), 1'b1, 1'b0);
    tick();
    check("post_rst_vld",  64'(bus.out_vld),  64'd1);
    check("post_rst_data", 64'(bus.out_data), 64'h77);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
